// File: rtl/ula_multiciclo.sv
`timescale 1ns/1ps
// Multi-cycle MIPS ALU: single-cycle simple ops, iterative shift-add multiply and
// restoring divide sharing one double-width accumulator, start/busy/done handshake.
module ula_multiciclo #(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [2:0]         opCode,
  input  logic [LARGURA-1:0] operador1,
  input  logic [LARGURA-1:0] operador2,
  output logic [LARGURA-1:0] resultado,
  output logic [LARGURA-1:0] resultadoHi,
  output logic               isZero,
  output logic               divZero,
  output logic               ocupado,
  output logic               pronto
);

  localparam int CW = $clog2(LARGURA);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_EQ   = 3'b011;
  localparam logic [2:0] OP_LESS = 3'b100;
  localparam logic [2:0] OP_MULT = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic [1:0] {OCIOSO, MULT, DIV, FIM} estado_t;

  estado_t              r_estado;
  logic [CW-1:0]        r_cont;
  logic [2*LARGURA-1:0] r_acc;   // {HI, LO}: product accumulator or {remainder, quotient}
  logic [LARGURA-1:0]   r_op2;   // multiplicand or divisor
  logic [LARGURA-1:0]   r_resultado;
  logic [LARGURA-1:0]   r_resultado_hi;
  logic                 r_is_zero;
  logic                 r_div_zero;
  logic                 r_ocupado;
  logic                 r_pronto;

  logic [LARGURA-1:0]   w_simples;
  logic [LARGURA-1:0]   w_hi;
  logic [LARGURA-1:0]   w_lo;
  logic [LARGURA:0]     w_soma;
  logic [LARGURA:0]     w_resto_desl;
  logic [LARGURA:0]     w_dif;
  logic                 w_subtrai;
  logic [2*LARGURA-1:0] w_passo;

  always_comb begin
    w_simples = '0;
    case (opCode)
      OP_ADD:  w_simples = operador1 + operador2;
      OP_SUB:  w_simples = operador1 - operador2;
      OP_OR:   w_simples = operador1 | operador2;
      OP_EQ:   w_simples = {{(LARGURA-1){1'b0}}, (operador1 == operador2)};
      OP_LESS: w_simples = {{(LARGURA-1){1'b0}}, (operador1 < operador2)};
      OP_AND:  w_simples = operador1 & operador2;
      default: w_simples = '0;
    endcase
  end

  // One iteration of either engine; the state selects which one is committed.
  always_comb begin
    w_hi         = r_acc[2*LARGURA-1:LARGURA];
    w_lo         = r_acc[LARGURA-1:0];
    w_soma       = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_op2} : '0);
    w_resto_desl = {w_hi, w_lo[LARGURA-1]};
    w_dif        = w_resto_desl - {1'b0, r_op2};
    w_subtrai    = (w_resto_desl >= {1'b0, r_op2});
    w_passo      = {w_soma, w_lo[LARGURA-1:1]};
    if (r_estado == DIV) begin
      if (w_subtrai)
        w_passo = {w_dif[LARGURA-1:0], w_lo[LARGURA-2:0], 1'b1};
      else
        w_passo = {w_resto_desl[LARGURA-1:0], w_lo[LARGURA-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado       <= OCIOSO;
      r_cont         <= '0;
      r_acc          <= '0;
      r_op2          <= '0;
      r_resultado    <= '0;
      r_resultado_hi <= '0;
      r_is_zero      <= 1'b0;
      r_div_zero     <= 1'b0;
      r_ocupado      <= 1'b0;
      r_pronto       <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          r_pronto <= 1'b0;
          if (inicio) begin
            r_ocupado <= 1'b1;
            r_cont    <= CW'(LARGURA - 1);
            if (opCode == OP_MULT) begin
              r_acc    <= {{LARGURA{1'b0}}, operador2};
              r_op2    <= operador1;
              r_estado <= MULT;
            end else if (opCode == OP_DIV && operador2 != '0) begin
              r_acc    <= {{LARGURA{1'b0}}, operador1};
              r_op2    <= operador2;
              r_estado <= DIV;
            end else if (opCode == OP_DIV) begin
              r_resultado    <= '1;
              r_resultado_hi <= operador1;
              r_is_zero      <= 1'b0;
              r_div_zero     <= 1'b1;
              r_pronto       <= 1'b1;
              r_estado       <= FIM;
            end else begin
              r_resultado    <= w_simples;
              r_resultado_hi <= '0;
              r_is_zero      <= (w_simples == '0);
              r_div_zero     <= 1'b0;
              r_pronto       <= 1'b1;
              r_estado       <= FIM;
            end
          end
        end
        MULT, DIV: begin
          r_acc <= w_passo;
          if (r_cont == '0) begin
            r_resultado    <= w_passo[LARGURA-1:0];
            r_resultado_hi <= w_passo[2*LARGURA-1:LARGURA];
            r_is_zero      <= (w_passo[LARGURA-1:0] == '0);
            r_div_zero     <= 1'b0;
            r_pronto       <= 1'b1;
            r_estado       <= FIM;
          end else begin
            r_cont <= r_cont - 1'b1;
          end
        end
        FIM: begin
          r_pronto  <= 1'b0;
          r_ocupado <= 1'b0;
          r_estado  <= OCIOSO;
        end
      endcase
    end
  end

  assign resultado   = r_resultado;
  assign resultadoHi = r_resultado_hi;
  assign isZero      = r_is_zero;
  assign divZero     = r_div_zero;
  assign ocupado     = r_ocupado;
  assign pronto      = r_pronto;

endmodule

// File: tb/tb_ula_multiciclo.sv
`timescale 1ns/1ps
// Directed bench for ula_multiciclo: default 32-bit instance plus an 8-bit instance.
module tb_ula_multiciclo;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_EQ   = 3'b011;
  localparam logic [2:0] OP_LESS = 3'b100;
  localparam logic [2:0] OP_MULT = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inicio = 1'b0;
  logic [2:0]  opCode = 3'b000;
  logic [31:0] operador1 = '0, operador2 = '0;
  logic [31:0] resultado, resultadoHi;
  logic        isZero, divZero, ocupado, pronto;

  logic        inicio8 = 1'b0;
  logic [2:0]  opCode8 = 3'b000;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  res8, hi8;
  logic        z8, dz8, oc8, pr8;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ula_multiciclo #(.LARGURA(32)) dut (
    .clock(clock), .reset(reset), .inicio(inicio), .opCode(opCode),
    .operador1(operador1), .operador2(operador2),
    .resultado(resultado), .resultadoHi(resultadoHi), .isZero(isZero),
    .divZero(divZero), .ocupado(ocupado), .pronto(pronto)
  );

  ula_multiciclo #(.LARGURA(8)) dut8 (
    .clock(clock), .reset(reset), .inicio(inicio8), .opCode(opCode8),
    .operador1(a8), .operador2(b8),
    .resultado(res8), .resultadoHi(hi8), .isZero(z8),
    .divZero(dz8), .ocupado(oc8), .pronto(pr8)
  );

  // Waits for idle, issues one request and returns the accept-to-pronto latency.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    int guard = 0;
    @(negedge clock);
    while (ocupado === 1'b1 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    opCode = op; operador1 = a; operador2 = b; inicio = 1'b1;
    @(posedge clock); #1;
    inicio = 1'b0;
    lat = 1;
    while (pronto !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    $display("op=%0d a=%h b=%h -> res=%h hi=%h z=%b dz=%b lat=%0d",
             op, a, b, resultado, resultadoHi, isZero, divZero, lat);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({resultado, resultadoHi, isZero, divZero, ocupado, pronto} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got res=%h hi=%h z=%b dz=%b oc=%b pr=%b want all 0",
               resultado, resultadoHi, isZero, divZero, ocupado, pronto);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_simple();
    int lat;
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat);
    checks++;
    if (lat !== 1 || resultado !== 32'h0 || isZero !== 1'b1 || resultadoHi !== 32'h0
        || ocupado !== 1'b1) begin
      failures++;
      $display("FAIL add_wrap got lat=%0d res=%h z=%b hi=%h oc=%b want 1 0 1 0 1",
               lat, resultado, isZero, resultadoHi, ocupado);
    end
    @(posedge clock); #1;
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0) begin
      failures++;
      $display("FAIL add_ocupado_1cycle got oc=%b pr=%b want 0 0", ocupado, pronto);
    end
    run_op(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, lat);
    checks++;
    if (resultado !== 32'hF0F0_0F0F || lat !== 1) begin
      failures++;
      $display("FAIL or got %h lat=%0d want f0f00f0f 1", resultado, lat);
    end
    run_op(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, lat);
    checks++;
    if (resultado !== 32'h0F00_0F00) begin
      failures++;
      $display("FAIL and got %h want 0f000f00", resultado);
    end
    run_op(OP_EQ, 32'd5, 32'd5, lat);
    checks++;
    if (resultado !== 32'd1 || isZero !== 1'b0) begin
      failures++;
      $display("FAIL equal got %h z=%b want 1 0", resultado, isZero);
    end
    run_op(OP_LESS, 32'h8000_0000, 32'h1, lat);
    checks++;
    if (resultado !== 32'd0 || isZero !== 1'b1) begin
      failures++;
      $display("FAIL less_unsigned got %h z=%b want 0 1", resultado, isZero);
    end
    run_op(OP_SUB, 32'd3, 32'd5, lat);
    checks++;
    if (resultado !== 32'hFFFF_FFFE || isZero !== 1'b0 || resultadoHi !== 32'h0) begin
      failures++;
      $display("FAIL sub got %h z=%b hi=%h want fffffffe 0 0", resultado, isZero, resultadoHi);
    end
  endtask

  task automatic test_mult();
    int bad = 0;
    int lat;
    @(negedge clock);
    @(negedge clock);
    opCode = OP_MULT; operador1 = 32'hFFFF_FFFF; operador2 = 32'hFFFF_FFFF; inicio = 1'b1;
    @(posedge clock); #1;
    inicio = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
      end
      if (pronto !== 1'b0 || resultado !== 32'hFFFF_FFFE || resultadoHi !== 32'h0
          || ocupado !== 1'b1)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL mult_hold got %0d disturbed cycles want 0", bad);
    end
    @(posedge clock); #1;
    $display("op=%0d a=ffffffff b=ffffffff -> res=%h hi=%h pr=%b at cycle 33",
             OP_MULT, resultado, resultadoHi, pronto);
    checks++;
    if (pronto !== 1'b1 || resultadoHi !== 32'hFFFF_FFFE || resultado !== 32'h1) begin
      failures++;
      $display("FAIL mult_max got pr=%b hi=%h lo=%h want 1 fffffffe 00000001",
               pronto, resultadoHi, resultado);
    end
    run_op(OP_MULT, 32'h1234_5678, 32'h10, lat);
    checks++;
    if (resultadoHi !== 32'h1 || resultado !== 32'h2345_6780 || lat !== 33) begin
      failures++;
      $display("FAIL mult_shift got hi=%h lo=%h lat=%0d want 1 23456780 33",
               resultadoHi, resultado, lat);
    end
  endtask

  task automatic test_div();
    int lat;
    run_op(OP_DIV, 32'd100, 32'd7, lat);
    checks++;
    if (resultado !== 32'd14 || resultadoHi !== 32'd2 || divZero !== 1'b0 || lat !== 33) begin
      failures++;
      $display("FAIL div_100_7 got q=%0d r=%0d dz=%b lat=%0d want 14 2 0 33",
               resultado, resultadoHi, divZero, lat);
    end
    run_op(OP_DIV, 32'hFFFF_FFFF, 32'h10, lat);
    checks++;
    if (resultado !== 32'h0FFF_FFFF || resultadoHi !== 32'hF) begin
      failures++;
      $display("FAIL div_big got q=%h r=%h want 0fffffff f", resultado, resultadoHi);
    end
    run_op(OP_DIV, 32'd5, 32'd0, lat);
    checks++;
    if (resultado !== 32'hFFFF_FFFF || resultadoHi !== 32'd5 || divZero !== 1'b1
        || isZero !== 1'b0 || lat !== 1) begin
      failures++;
      $display("FAIL div_zero got q=%h r=%h dz=%b z=%b lat=%0d want ffffffff 5 1 0 1",
               resultado, resultadoHi, divZero, isZero, lat);
    end
    run_op(OP_ADD, 32'd1, 32'd2, lat);
    checks++;
    if (divZero !== 1'b0 || resultado !== 32'd3) begin
      failures++;
      $display("FAIL divzero_clear got dz=%b res=%0d want 0 3", divZero, resultado);
    end
  endtask

  task automatic test_back_to_back();
    int n_pronto = 0;
    int lat;
    @(negedge clock);
    @(negedge clock);
    opCode = OP_MULT; operador1 = 32'd3; operador2 = 32'd4; inicio = 1'b1;
    @(posedge clock); #1;
    opCode = OP_ADD; operador1 = 32'd7; operador2 = 32'd9;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
      end
      if (k == 10) inicio = 1'b0;
      if (pronto === 1'b1) n_pronto++;
    end
    $display("op=%0d a=3 b=4 with ignored starts -> res=%0d pulses=%0d",
             OP_MULT, resultado, n_pronto);
    checks++;
    if (n_pronto !== 1 || resultado !== 32'd12) begin
      failures++;
      $display("FAIL ignore_inicio got pulses=%0d res=%0d want 1 12", n_pronto, resultado);
    end
    run_op(OP_MULT, 32'd2, 32'd2, lat);
    opCode = OP_ADD; operador1 = 32'd1; operador2 = 32'd1; inicio = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (pronto !== 1'b0 || ocupado !== 1'b0) begin
      failures++;
      $display("FAIL fim_ignores_inicio got pr=%b oc=%b want 0 0", pronto, ocupado);
    end
    @(posedge clock); #1;
    inicio = 1'b0;
    $display("op=%0d a=1 b=1 after FIM -> res=%0d pr=%b", OP_ADD, resultado, pronto);
    checks++;
    if (pronto !== 1'b1 || resultado !== 32'd2) begin
      failures++;
      $display("FAIL accept_after_fim got pr=%b res=%0d want 1 2", pronto, resultado);
    end
  endtask

  task automatic test_reset_mid();
    int n_pronto = 0;
    int lat;
    run_op(OP_DIV, 32'd9, 32'd0, lat);
    @(negedge clock);
    @(negedge clock);
    opCode = OP_MULT; operador1 = 32'd6; operador2 = 32'd7; inicio = 1'b1;
    @(posedge clock); #1;
    inicio = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({resultado, resultadoHi, isZero, divZero, ocupado, pronto} !== '0) begin
      failures++;
      $display("FAIL reset_async got res=%h hi=%h z=%b dz=%b oc=%b pr=%b want all 0",
               resultado, resultadoHi, isZero, divZero, ocupado, pronto);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (pronto === 1'b1) n_pronto++;
    end
    checks++;
    if (n_pronto !== 0) begin
      failures++;
      $display("FAIL reset_no_pronto got %0d pulses want 0", n_pronto);
    end
    run_op(OP_LESS, 32'd2, 32'd3, lat);
    checks++;
    if (resultado !== 32'd1 || lat !== 1) begin
      failures++;
      $display("FAIL less_after_reset got %0d lat=%0d want 1 1", resultado, lat);
    end
  endtask

  task automatic test_param8();
    int lat;
    @(negedge clock);
    opCode8 = OP_MULT; a8 = 8'hFF; b8 = 8'hFF; inicio8 = 1'b1;
    @(posedge clock); #1;
    inicio8 = 1'b0;
    lat = 1;
    while (pr8 !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    $display("w8 op=%0d a=ff b=ff -> res=%h hi=%h lat=%0d", OP_MULT, res8, hi8, lat);
    checks++;
    if (hi8 !== 8'hFE || res8 !== 8'h01 || lat !== 9) begin
      failures++;
      $display("FAIL w8_mult got hi=%h lo=%h lat=%0d want fe 01 9", hi8, res8, lat);
    end
    @(negedge clock);
    @(negedge clock);
    opCode8 = OP_LESS; a8 = 8'h80; b8 = 8'h01; inicio8 = 1'b1;
    @(posedge clock); #1;
    inicio8 = 1'b0;
    $display("w8 op=%0d a=80 b=01 -> res=%h pr=%b", OP_LESS, res8, pr8);
    checks++;
    if (res8 !== 8'h00 || pr8 !== 1'b1 || z8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_less got res=%h pr=%b z=%b want 00 1 1", res8, pr8, z8);
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_mid();
    test_param8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised multi-cycle ALU for the MIPS datapath, replacing the single-cycle combinational ALU wherever multiply and divide must not sit on the critical path. Simple operations (add, sub, or, and, equal, less) finish in one registered cycle. Multiply uses an iterative shift-add engine and divide uses a restoring engine. Both produce a double-width result split into `resultado` (LO) and `resultadoHi` (HI), matching MIPS HI/LO semantics, under a start/busy/done handshake driven by the control unit.

## Interface
- `LARGURA`, 32: operand and result width. Minimum is 4.
- `clock` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high. Clears all state immediately.
- `inicio` input 1: start request. Sampled only in state OCIOSO.
- `opCode` input 3: operation select. Add=000, Sub=001, Or=010, Equal=011, Less=100, Mult=101, Div=110, And=111.
- `operador1` input LARGURA: left operand.
- `operador2` input LARGURA: right operand.
- `resultado` output LARGURA: result, or LO of a product, or quotient.
- `resultadoHi` output LARGURA: HI of a product, or remainder. 0 for simple operations.
- `isZero` output 1: 1 when `resultado` == 0. Registered together with `resultado`.
- `divZero` output 1: 1 when the last completed Div had `operador2` == 0.
- `ocupado` output 1: 1 from the accepting edge until the cycle `pronto` is high, inclusive.
- `pronto` output 1: one-cycle pulse marking valid outputs.

## Operation
- Reset value of every output: 0 (`resultado`, `resultadoHi`, `isZero`, `divZero`, `ocupado`, `pronto`). State returns to OCIOSO and the iteration counter clears.
- States:
  - OCIOSO → FIM when `inicio`=1 with a simple op, or with Div and `operador2`==0.
  - OCIOSO → MULT when `inicio`=1 with Mult.
  - OCIOSO → DIV when `inicio`=1 with Div and `operador2`≠0.
  - MULT and DIV → FIM after LARGURA iterations.
  - FIM → OCIOSO unconditionally.
- On acceptance:
  - Latch `opCode`, `operador1`, `operador2`.
  - Load counter with LARGURA-1.
  - Later changes on the inputs have no effect on the operation in flight.
- Arithmetic is unsigned throughout:
  - Add/Sub wrap modulo 2^LARGURA.
  - Less is an unsigned compare; result is 1 or 0.
  - Equal result is 1 or 0.
  - Or/And are bitwise.
- MULT:
  - One partial-product step per cycle over a 2·LARGURA accumulator, shifting the multiplier right.
  - Final LO goes to `resultado`, HI to `resultadoHi`.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Quotient goes to `resultado`, remainder to `resultadoHi`.
- Div by zero: `resultado`=all ones, `resultadoHi`=`operador1`, `divZero`=1. Takes the simple-op latency.
- `divZero` is cleared on completion of any other operation.
- `resultado`, `resultadoHi`, `isZero`, `divZero`:
  - Update only in the cycle `pronto` asserts.
  - Hold until the next completion.
  - Intermediate accumulator values never appear on the outputs.
- `inicio` while `ocupado`=1 is ignored. No queuing.
- `inicio` sampled in FIM is also ignored. The earliest new accept is the edge after FIM.

## Timing
- Accept edge E: `inicio`=1 in OCIOSO.
- Simple ops and div-by-zero:
  - State is FIM after E.
  - `pronto`=1 and outputs valid for the one cycle after E.
  - Latency 1 cycle.
- Mult/Div:
  - Iterations occupy the cycles after edges E … E+LARGURA-1.
  - FIM after edge E+LARGURA.
  - `pronto`=1 for one cycle. Latency LARGURA+1 cycles (33 at default).
- `ocupado` is 1 in MULT, DIV and FIM, and 0 only in OCIOSO.
- Back-to-back throughput:
  - Simple ops: one accept every 2 cycles.
  - Mult/Div: one accept every LARGURA+2 cycles.
- Reset mid-operation:
  - Outputs go to 0 asynchronously.
  - No `pronto` is produced for the aborted operation.
  - The first accept is possible on the first edge after `reset` deasserts.
- The iteration counter is a ceil(log2(LARGURA))-bit down-counter.
  - Reaching 0 in MULT/DIV forces the transition to FIM on the next edge.
  - The counter never wraps.

## Test plan
- Add 0xFFFFFFFF + 1 → `pronto` 1 cycle after accept; `resultado`=0, `isZero`=1, `resultadoHi`=0, `ocupado` high exactly 1 cycle. Then Sub 3-5 → `resultado`=0xFFFFFFFE, `isZero`=0.
- Mult 0xFFFFFFFF × 0xFFFFFFFF → `pronto` exactly 33 cycles after accept; `resultadoHi`=0xFFFFFFFE, `resultado`=0x00000001. Outputs hold previous values during all 32 iterations.
- Div 100 ÷ 7 → `resultado`=14, `resultadoHi`=2, `divZero`=0, latency 33. Div 5 ÷ 0 → `resultado`=0xFFFFFFFF, `resultadoHi`=5, `divZero`=1, latency 1. A following Add clears `divZero`.
- Mult 3×4 accepted, then `inicio` with Add and changed operands held high for 10 cycles mid-operation → ignored; single `pronto` with `resultado`=12. Next Add is accepted only on the edge after FIM.
- Reset pulse at iteration 10 of a Mult → all outputs 0 immediately, no `pronto` ever. Post-reset Less 2 < 3 → `resultado`=1 after 1 cycle.
- Parameter sweep LARGURA=8: Mult 0xFF×0xFF → HI=0xFE, LO=0x01, latency 9. Less 0x80 < 0x01 → 0 (unsigned).
